// File: rtl/sphere_scanner_if.sv
// -----------------------------------------------------------------------------
// sphere_scanner_if
//   Bundles every non-clock signal of the sphere scanner.
//   - Ray request: start, ray_origin, ray_dir
//   - Sphere table bus: obj_id (to the table), sphere_center, sphere_r2 and
//     mat_id (back from the table, one cycle after obj_id)
//   - Result: busy, done, hit, hit_obj_id, hit_mat_id, hit_tca
//   The master modport belongs to whatever surrounds the scanner: it issues
//   rays and plays the table. The slave modport is the scanner itself.
//   All vectors are {z,y,x}, with each axis a signed Q8.24 word and x in [31:0].
// -----------------------------------------------------------------------------
interface sphere_scanner_if #(
    parameter int OBJ_W = 3
);
    logic             start;
    logic [95:0]      ray_origin;
    logic [95:0]      ray_dir;
    logic [OBJ_W-1:0] obj_id;
    logic [95:0]      sphere_center;
    logic [31:0]      sphere_r2;
    logic [2:0]       mat_id;
    logic             busy;
    logic             done;
    logic             hit;
    logic [OBJ_W-1:0] hit_obj_id;
    logic [2:0]       hit_mat_id;
    logic [31:0]      hit_tca;

    modport master (
        output start, ray_origin, ray_dir, sphere_center, sphere_r2, mat_id,
        input  obj_id, busy, done, hit, hit_obj_id, hit_mat_id, hit_tca
    );

    modport slave (
        input  start, ray_origin, ray_dir, sphere_center, sphere_r2, mat_id,
        output obj_id, busy, done, hit, hit_obj_id, hit_mat_id, hit_tca
    );
endinterface

// File: rtl/sphere_scanner.sv
// -----------------------------------------------------------------------------
// sphere_scanner
//   Walks the sphere table for a single ray and reports the nearest sphere
//   whose closest-approach point lies in front of the ray origin and inside
//   the sphere. Each object takes four cycles:
//     FETCH : obj_id is stable and the table registers the entry
//     LOAD  : L = center - origin, plus r2 and mat_id, are latched
//     DOT   : tca = L.D and ll = L.L are latched
//     TEST  : d2 = ll - tca^2; a hit needs tca > 0, r2 >= 0 and d2 <= r2
//   After the last object, DONE pulses done for one cycle and drops busy.
//
// Ports:
//   clk    - clock, all logic on the rising edge
//   rst_n  - asynchronous active-low reset; aborts a scan without done
//   bus    - sphere_scanner_if slave modport (ray in, table bus, result out)
//
// Parameters:
//   NUM_OBJ - table entries scanned, ids 0..NUM_OBJ-1 (1..8)
//   OBJ_W   - width of obj_id / hit_obj_id
// -----------------------------------------------------------------------------
module sphere_scanner #(
    parameter int NUM_OBJ = 3,
    parameter int OBJ_W   = 3
) (
    input logic              clk,
    input logic              rst_n,
    sphere_scanner_if.slave  bus
);

    localparam logic [OBJ_W-1:0] LAST_ID = OBJ_W'(NUM_OBJ - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        DOT,
        TEST,
        DONE
    } state_t;

    state_t state;

    // Ray captured at start so the inputs may change during the scan.
    logic [95:0] org_q;
    logic [95:0] dir_q;

    // Per-object pipeline registers.
    logic signed [31:0] lx_q, ly_q, lz_q;
    logic signed [31:0] r2_q;
    logic [2:0]         mat_q;
    logic signed [31:0] tca_q;
    logic signed [31:0] ll_q;

    logic signed [31:0] ox, oy, oz;
    logic signed [31:0] dx, dy, dz;

    assign ox = org_q[31:0];
    assign oy = org_q[63:32];
    assign oz = org_q[95:64];
    assign dx = dir_q[31:0];
    assign dy = dir_q[63:32];
    assign dz = dir_q[95:64];

    // Q8.24 multiply: full signed 64-bit product, keep the middle 32 bits.
    function automatic logic signed [31:0] qmul(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return p[55:24];
    endfunction

    logic signed [31:0] tca_n;
    logic signed [31:0] ll_n;
    logic signed [31:0] d2;
    logic               is_hit;
    logic               better;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        tca_n  = '0;
        ll_n   = '0;
        d2     = '0;
        is_hit = 1'b0;
        better = 1'b0;

        tca_n = qmul(lx_q, dx) + qmul(ly_q, dy) + qmul(lz_q, dz);
        ll_n  = qmul(lx_q, lx_q) + qmul(ly_q, ly_q) + qmul(lz_q, lz_q);
        d2    = ll_n - qmul(tca_q, tca_q);

        // A negative r2 (unused slots read as all-ones) must never hit, even
        // if truncation leaves d2 slightly negative.
        is_hit = (tca_q > 32'sd0) && !r2_q[31] && (d2 <= r2_q);

        // Strictly closer only, so on equal tca the earlier (lower) id stays.
        better = is_hit && (!bus.hit || (tca_q < $signed(bus.hit_tca)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            org_q          <= '0;
            dir_q          <= '0;
            lx_q           <= '0;
            ly_q           <= '0;
            lz_q           <= '0;
            r2_q           <= '0;
            mat_q          <= '0;
            tca_q          <= '0;
            ll_q           <= '0;
            bus.obj_id     <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.hit        <= 1'b0;
            bus.hit_obj_id <= '0;
            bus.hit_mat_id <= '0;
            bus.hit_tca    <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the values from before this edge.
            bus.done <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        org_q          <= bus.ray_origin;
                        dir_q          <= bus.ray_dir;
                        bus.obj_id     <= '0;
                        bus.hit        <= 1'b0;
                        bus.hit_obj_id <= '0;
                        bus.hit_mat_id <= '0;
                        bus.hit_tca    <= '0;
                        bus.busy       <= 1'b1;
                        state          <= FETCH;
                    end
                end

                FETCH: state <= LOAD;

                LOAD: begin
                    lx_q  <= $signed(bus.sphere_center[31:0])  - ox;
                    ly_q  <= $signed(bus.sphere_center[63:32]) - oy;
                    lz_q  <= $signed(bus.sphere_center[95:64]) - oz;
                    r2_q  <= $signed(bus.sphere_r2);
                    mat_q <= bus.mat_id;
                    state <= DOT;
                end

                DOT: begin
                    tca_q <= tca_n;
                    ll_q  <= ll_n;
                    state <= TEST;
                end

                TEST: begin
                    if (better) begin
                        bus.hit        <= 1'b1;
                        bus.hit_obj_id <= bus.obj_id;
                        bus.hit_mat_id <= mat_q;
                        bus.hit_tca    <= tca_q;
                    end
                    if (bus.obj_id == LAST_ID) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        bus.obj_id <= bus.obj_id + OBJ_W'(1);
                        state      <= FETCH;
                    end
                end

                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sphere_scanner.sv
// -----------------------------------------------------------------------------
// tb_sphere_scanner
//   Two scanners share one ray stream: a 3-object one and a 4-object one
//   whose extra slot reads as all-ones. Each has its own registered table
//   model. Every scan runs a fixed 30-cycle window; cycle n is the value the
//   n-th rising edge after the start-sampling edge will see, sampled on the
//   falling edge before it.
// -----------------------------------------------------------------------------
module tb_sphere_scanner;

    localparam logic [31:0] ONE   = 32'd16777216;
    localparam logic [31:0] HALF  = 32'd8388608;
    localparam logic [31:0] T3_0  = 32'd50331648;
    localparam logic [31:0] T5_0  = 32'd83886080;
    localparam logic [31:0] T7_0  = 32'd117440512;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [95:0] ray_origin;
    logic [95:0] ray_dir;

    int vectors;
    int miscompares;

    sphere_scanner_if #(.OBJ_W(3)) bus3 ();
    sphere_scanner_if #(.OBJ_W(3)) bus4 ();

    sphere_scanner #(.NUM_OBJ(3), .OBJ_W(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
    sphere_scanner #(.NUM_OBJ(4), .OBJ_W(3)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    assign bus3.start      = start;
    assign bus3.ray_origin = ray_origin;
    assign bus3.ray_dir    = ray_dir;
    assign bus4.start      = start;
    assign bus4.ray_origin = ray_origin;
    assign bus4.ray_dir    = ray_dir;

    // Sphere table contents; entry 3 is only reachable by the 4-object scanner.
    logic [95:0] tbl_c  [4];
    logic [31:0] tbl_r2 [4];
    logic [2:0]  tbl_m  [4];

    // Table model: one-cycle registered read.
    always @(posedge clk) begin
        bus3.sphere_center <= tbl_c[bus3.obj_id];
        bus3.sphere_r2     <= tbl_r2[bus3.obj_id];
        bus3.mat_id        <= tbl_m[bus3.obj_id];
        bus4.sphere_center <= tbl_c[bus4.obj_id];
        bus4.sphere_r2     <= tbl_r2[bus4.obj_id];
        bus4.mat_id        <= tbl_m[bus4.obj_id];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [95:0] v3(input int x, input int y, input int z);
        return {32'(z * 16777216), 32'(y * 16777216), 32'(x * 16777216)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-scan observations.
    int          lat3, lat4, nd3, nd4;
    logic        busy3_first, busy4_first, busy3_after, busy4_after;
    logic        hit3, hit4;
    logic [2:0]  obj3, obj4, mat3, mat4;
    logic [31:0] tca3, tca4;
    logic [2:0]  obj4_seq [4];

    // Starts a scan on the current falling edge and watches 30 cycles.
    // pulses[n] drives start again in cycle n; rst_at > 0 pulses reset there.
    task automatic run_scan(input logic [95:0] org, input logic [95:0] dir,
                            input logic [31:0] pulses, input int rst_at);
        lat3 = 0; lat4 = 0; nd3 = 0; nd4 = 0;
        busy3_first = 1'b0; busy4_first = 1'b0;
        busy3_after = 1'bx; busy4_after = 1'bx;
        ray_origin = org;
        ray_dir    = dir;
        start      = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            start      = pulses[cyc];
            ray_origin = {$urandom(), $urandom(), $urandom()};
            ray_dir    = {$urandom(), $urandom(), $urandom()};
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst busy3",  {63'd0, bus3.busy}, 64'd0);
                check("rst busy4",  {63'd0, bus4.busy}, 64'd0);
                check("rst done3",  {63'd0, bus3.done}, 64'd0);
                check("rst hit3",   {63'd0, bus3.hit},  64'd0);
                check("rst obj_id3", {61'd0, bus3.obj_id}, 64'd0);
                check("rst obj_id4", {61'd0, bus4.obj_id}, 64'd0);
                check("rst hit_obj3", {61'd0, bus3.hit_obj_id}, 64'd0);
                check("rst hit_mat3", {61'd0, bus3.hit_mat_id}, 64'd0);
                check("rst hit_tca3", {32'd0, bus3.hit_tca}, 64'd0);
            end else begin
                rst_n = 1'b1;
            end
            if (cyc == 1) begin
                busy3_first = bus3.busy;
                busy4_first = bus4.busy;
            end
            if ((cyc % 4) == 1 && cyc <= 13) obj4_seq[(cyc - 1) / 4] = bus4.obj_id;
            if (lat3 != 0 && cyc == lat3 + 1) busy3_after = bus3.busy;
            if (lat4 != 0 && cyc == lat4 + 1) busy4_after = bus4.busy;
            if (bus3.done === 1'b1) begin
                nd3++;
                if (lat3 == 0) begin
                    lat3 = cyc;
                    hit3 = bus3.hit; obj3 = bus3.hit_obj_id;
                    mat3 = bus3.hit_mat_id; tca3 = bus3.hit_tca;
                end
            end
            if (bus4.done === 1'b1) begin
                nd4++;
                if (lat4 == 0) begin
                    lat4 = cyc;
                    hit4 = bus4.hit; obj4 = bus4.hit_obj_id;
                    mat4 = bus4.hit_mat_id; tca4 = bus4.hit_tca;
                end
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic check_scan(input string tag, input logic e_hit, input logic [2:0] e_obj,
                              input logic [2:0] e_mat, input logic [31:0] e_tca);
        check({tag, " latency3"}, 64'(lat3), 64'd13);
        check({tag, " latency4"}, 64'(lat4), 64'd17);
        check({tag, " done_count3"}, 64'(nd3), 64'd1);
        check({tag, " done_count4"}, 64'(nd4), 64'd1);
        check({tag, " busy_first3"}, {63'd0, busy3_first}, 64'd1);
        check({tag, " busy_first4"}, {63'd0, busy4_first}, 64'd1);
        check({tag, " busy_after3"}, {63'd0, busy3_after}, 64'd0);
        check({tag, " busy_after4"}, {63'd0, busy4_after}, 64'd0);
        check({tag, " hit3"}, {63'd0, hit3}, {63'd0, e_hit});
        check({tag, " hit4"}, {63'd0, hit4}, {63'd0, e_hit});
        check({tag, " hit_obj3"}, {61'd0, obj3}, {61'd0, e_obj});
        check({tag, " hit_obj4"}, {61'd0, obj4}, {61'd0, e_obj});
        check({tag, " hit_mat3"}, {61'd0, mat3}, {61'd0, e_mat});
        check({tag, " hit_mat4"}, {61'd0, mat4}, {61'd0, e_mat});
        check({tag, " hit_tca3"}, {32'd0, tca3}, {32'd0, e_tca});
        check({tag, " hit_tca4"}, {32'd0, tca4}, {32'd0, e_tca});
        check({tag, " hold_tca3"}, {32'd0, bus3.hit_tca}, {32'd0, e_tca});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        ray_origin  = '0;
        ray_dir     = '0;

        tbl_c[0] = v3(0, 0, 0);   tbl_r2[0] = ONE;   tbl_m[0] = 3'd0;
        tbl_c[1] = v3(2, 0, 0);   tbl_r2[1] = HALF;  tbl_m[1] = 3'd1;
        tbl_c[2] = v3(-2, 0, 0);  tbl_r2[2] = HALF;  tbl_m[2] = 3'd2;
        tbl_c[3] = '1;            tbl_r2[3] = '1;    tbl_m[3] = '1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset busy3",  {63'd0, bus3.busy}, 64'd0);
        check("reset done3",  {63'd0, bus3.done}, 64'd0);
        check("reset hit3",   {63'd0, bus3.hit},  64'd0);
        check("reset obj_id3", {61'd0, bus3.obj_id}, 64'd0);
        check("reset hit_tca4", {32'd0, bus4.hit_tca}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Along +x from x=-5: obj2 at tca 3.0 is nearest.
        run_scan(v3(-5, 0, 0), v3(1, 0, 0), 32'd0, 0);
        check_scan("xaxis", 1'b1, 3'd2, 3'd2, T3_0);
        check("obj_id_seq0", {61'd0, obj4_seq[0]}, 64'd0);
        check("obj_id_seq1", {61'd0, obj4_seq[1]}, 64'd1);
        check("obj_id_seq2", {61'd0, obj4_seq[2]}, 64'd2);
        check("obj_id_seq3", {61'd0, obj4_seq[3]}, 64'd3);

        // Everything behind the ray: miss clears the previous hit.
        run_scan(v3(5, 0, 0), v3(1, 0, 0), 32'd0, 0);
        check_scan("behind", 1'b0, 3'd0, 3'd0, 32'd0);

        // Down -y from y=5: only obj0 is hit, at 5.0.
        run_scan(v3(0, 5, 0), v3(0, -1, 0), 32'd0, 0);
        check_scan("yaxis", 1'b1, 3'd0, 3'd0, T5_0);

        // Along +x from y=5: obj0 tca = 0 (not > 0), others miss.
        run_scan(v3(0, 5, 0), v3(1, 0, 0), 32'd0, 0);
        check_scan("tca_zero", 1'b0, 3'd0, 3'd0, 32'd0);

        // Equal distance to obj1 and obj2 (both at x=2): lower id wins.
        tbl_c[0] = v3(4, 0, 0);
        tbl_c[2] = v3(2, 0, 0);
        run_scan(v3(-5, 0, 0), v3(1, 0, 0), 32'd0, 0);
        check_scan("tie", 1'b1, 3'd1, 3'd1, T7_0);
        tbl_c[0] = v3(0, 0, 0);
        tbl_c[2] = v3(-2, 0, 0);

        // start pulsed in cycles 3, 12 and 13 (DONE cycle of the 3-object
        // scanner) must all be ignored.
        run_scan(v3(-5, 0, 0), v3(1, 0, 0), (32'd1 << 3) | (32'd1 << 12) | (32'd1 << 13), 0);
        check_scan("restart_ignored", 1'b1, 3'd2, 3'd2, T3_0);

        // Reset in cycle 6 aborts the scan: no done, back to idle.
        run_scan(v3(0, 5, 0), v3(0, -1, 0), 32'd0, 6);
        check("abort done_count3", 64'(nd3), 64'd0);
        check("abort done_count4", 64'(nd4), 64'd0);
        check("abort busy3", {63'd0, bus3.busy}, 64'd0);
        check("abort busy4", {63'd0, bus4.busy}, 64'd0);

        // A fresh start after the abort completes normally.
        run_scan(v3(0, 5, 0), v3(0, -1, 0), 32'd0, 0);
        check_scan("after_abort", 1'b1, 3'd0, 3'd0, T5_0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sphere_scanner.md
Name: sphere_scanner

Overview:
- Sequential nearest-hit search over the scene sphere table for one ray.
- Drives obj_id into the sphere table ROM (registered, 1-cycle latency) and consumes sphere_center / sphere_r2 / mat_id.
- Runs a geometric ray-sphere test per object and reports the closest hit to the shading stage.
- Downstream neighbour of the sphere table; one ray in flight at a time.

Parameters:
- NUM_OBJ, 3, number of table entries scanned (ids 0..NUM_OBJ-1), 1..8
- OBJ_W, 3, width of obj_id

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a scan; sampled only in IDLE
- ray_origin  in  96  {z,y,x}, each signed Q8.24 (x in [31:0]); sampled at start
- ray_dir  in  96  {z,y,x}, signed Q8.24, unit length expected; sampled at start
- obj_id  out  OBJ_W  index presented to sphere table
- sphere_center  in  96  {z,y,x} signed Q8.24 from table
- sphere_r2  in  32  radius squared, signed Q8.24
- mat_id  in  3  material of the sphere
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse, results valid
- hit  out  1  at least one sphere hit
- hit_obj_id  out  OBJ_W  closest hit object
- hit_mat_id  out  3  its material
- hit_tca  out  32  signed Q8.24 distance along ray to closest approach

Behaviour:
- Reset (async, rst_n low): state IDLE; obj_id, busy, done, hit, hit_obj_id, hit_mat_id, hit_tca all 0; internal best cleared. Reset mid-scan aborts with no done.
- States: IDLE, FETCH, LOAD, DOT, TEST, DONE.
- IDLE: if start, latch ray_origin/ray_dir, obj_id<=0, clear best (hit=0, hit_tca=0, ids=0), busy<=1, go FETCH. Otherwise outputs hold the last results.
- FETCH: obj_id stable; table registers entry. Go LOAD.
- LOAD: table outputs valid; latch Lx/Ly/Lz = center - origin per axis, r2, mat_id. Go DOT.
- DOT: register tca = L·D and ll = L·L. Go TEST.
- TEST: d2 = ll - tca*tca. Hit when tca > 0 (strict) and d2 <= r2 (signed compare). If hit and (no best yet or tca < best tca strictly), update best. On a tie the lower obj_id is kept. If obj_id == NUM_OBJ-1, go DONE; else obj_id++, go FETCH.
- DONE: done=1 for exactly this cycle; busy<=0 at the exit edge; go IDLE.
- Latency: 4 cycles per object. done is high 4*NUM_OBJ+1 cycles after the start-sampling edge (13 for NUM_OBJ=3).
- Arithmetic:
  - Signed 32x32 to 64 products; Q8.24 result is product[55:24].
  - Sums and differences wrap at 32 bits, with no saturation.
  - Overflow beyond ±128 is undefined scene content and is not checked.
- Negative r2 (including all-ones from unused table slots) never produces a hit.
- start while busy is ignored. start asserted in the DONE cycle is ignored; it is accepted from IDLE on the next cycle.
- ray inputs may change freely after the start cycle.
- On a miss: hit=0, hit_obj_id=0, hit_mat_id=0, hit_tca=0.

Test Plan:
- Table {0: c(0,0,0) r2 1.0 mat0; 1: c(2,0,0) r2 0.5 mat1; 2: c(-2,0,0) r2 0.5 mat2}. origin(-5,0,0), dir(1,0,0) -> done at cycle 13, hit=1, hit_obj_id=2, hit_mat_id=2, hit_tca=50331648 (3.0).
- origin(0,5,0), dir(0,-1,0) -> sphere 1 misses (d2=4.0 > 0.5) -> hit=1, obj 0, mat 0, hit_tca=83886080 (5.0).
- origin(0,5,0), dir(1,0,0): obj0 tca=0 is not > 0 -> all miss -> hit=0, hit_obj_id=0, hit_tca=0.
- origin(5,0,0), dir(1,0,0): all spheres behind the ray -> hit=0.
- Pulse start again at cycles 3 and 12 of a scan -> ignored, single done. Then drop rst_n at cycle 6 of a new scan -> all outputs 0, IDLE, no done; a following start completes normally.
- NUM_OBJ=4 with slot 3 returning all-ones -> obj_id sequence 0,1,2,3, done at cycle 17, and slot 3 is never reported as hit.
